// File: rtl/clk_gen_sched.sv
// clk_gen_sched: round-robin arbiter and sequencer for a shared programmable
// clock generator. It grants divider-change requests from several correlator
// lines. It waits for a safe period boundary (generator overflow) before it
// loads the new divider. It also shuts the generator down in an orderly way.
module clk_gen_sched #(
  parameter int RESOLUTION = 32,
  parameter int NUM_LINES  = 4,
  parameter int IDX_W      = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_LINES-1:0]            req,
  input  logic [NUM_LINES*RESOLUTION-1:0] div_in,
  input  logic                            stop,
  input  logic                            gen_overflow,
  output logic [NUM_LINES-1:0]            ack,
  output logic                            err,
  output logic [RESOLUTION-1:0]           div_out,
  output logic                            gen_enable,
  output logic [IDX_W-1:0]                owner,
  output logic                            busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    WAIT   = 3'd2,
    LOAD   = 3'd3,
    REJECT = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t                 state, state_n;
  logic [IDX_W-1:0]       rr_ptr, rr_ptr_n;
  logic [IDX_W-1:0]       win_idx, win_idx_n;
  logic [RESOLUTION-1:0]  win_div, win_div_n;
  logic [RESOLUTION-1:0]  div_out_n;
  logic                   gen_enable_n;
  logic [IDX_W-1:0]       owner_n;
  logic [NUM_LINES-1:0]   ack_n;
  logic                   err_n;

  logic [NUM_LINES-1:0]   masked_req;
  logic                   found;
  logic [IDX_W-1:0]       pick;
  logic [IDX_W-1:0]       pick_next;
  logic [RESOLUTION-1:0]  pick_div;
  int                     cand;

  // A line whose ack is high this cycle has already been served, so it is
  // hidden from arbitration even if its req has not dropped yet.
  assign masked_req = req & ~ack;

  // Round-robin search: first unmasked requester at or after the pointer, wrapping.
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    pick_next = '0;
    pick_div  = '0;
    cand      = 0;
    for (int k = 0; k < NUM_LINES; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_LINES;
      if (!found && masked_req[cand]) begin
        found     = 1'b1;
        pick      = IDX_W'(cand);
        pick_next = IDX_W'((cand + 1) % NUM_LINES);
        pick_div  = div_in[cand*RESOLUTION +: RESOLUTION];
      end
    end
  end

  // Next-state and next-output logic for the sequencing FSM.
  always_comb begin
    state_n      = state;
    rr_ptr_n     = rr_ptr;
    win_idx_n    = win_idx;
    win_div_n    = win_div;
    div_out_n    = div_out;
    gen_enable_n = gen_enable;
    owner_n      = owner;
    ack_n        = '0;
    err_n        = 1'b0;
    case (state)
      IDLE, RUN: begin
        if (state == RUN && stop) begin
          state_n = HALT;
        end else if (found) begin
          win_idx_n = pick;
          win_div_n = pick_div;
          rr_ptr_n  = pick_next;
          state_n   = (pick_div < RESOLUTION'(2)) ? REJECT : WAIT;
        end
      end
      WAIT: begin
        if (!gen_enable || gen_overflow) begin
          state_n = LOAD;
        end
      end
      LOAD: begin
        div_out_n    = win_div;
        gen_enable_n = 1'b1;
        owner_n      = win_idx;
        ack_n        = NUM_LINES'(1) << win_idx;
        state_n      = RUN;
      end
      REJECT: begin
        ack_n   = NUM_LINES'(1) << win_idx;
        err_n   = 1'b1;
        state_n = gen_enable ? RUN : IDLE;
      end
      HALT: begin
        if (gen_overflow) begin
          gen_enable_n = 1'b0;
          state_n      = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight grant silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      win_idx    <= '0;
      win_div    <= '0;
      div_out    <= RESOLUTION'(2);
      gen_enable <= 1'b0;
      owner      <= '0;
      ack        <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      rr_ptr     <= rr_ptr_n;
      win_idx    <= win_idx_n;
      win_div    <= win_div_n;
      div_out    <= div_out_n;
      gen_enable <= gen_enable_n;
      owner      <= owner_n;
      ack        <= ack_n;
      err        <= err_n;
    end
  end

  assign busy = (state == WAIT) || (state == LOAD) || (state == REJECT) || (state == HALT);

endmodule

// File: tb/tb_clk_gen_sched.sv
// Directed self-checking bench for clk_gen_sched. Inputs change on the falling
// edge. Outputs are checked on the falling edge, away from the active edge.
module tb_clk_gen_sched;

  logic         clk;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] div_in;
  logic         stop;
  logic         gen_overflow;
  logic [3:0]   ack;
  logic         err;
  logic [31:0]  div_out;
  logic         gen_enable;
  logic [1:0]   owner;
  logic         busy;

  int checks;
  int failures;
  int waited;

  clk_gen_sched #(.RESOLUTION(32), .NUM_LINES(4), .IDX_W(2)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .div_in(div_in),
    .stop(stop),
    .gen_overflow(gen_overflow),
    .ack(ack),
    .err(err),
    .div_out(div_out),
    .gen_enable(gen_enable),
    .owner(owner),
    .busy(busy)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic s, input logic ov);
    req          = r;
    stop         = s;
    gen_overflow = ov;
  endtask

  task automatic setDiv(input int line, input logic [31:0] value);
    div_in[line*32 +: 32] = value;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_div_out"}, div_out, 32'd2);
    checkOutput({tag, "_gen_enable"}, {31'd0, gen_enable}, 32'd0);
    checkOutput({tag, "_ack"}, {28'd0, ack}, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
    checkOutput({tag, "_owner"}, {30'd0, owner}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Wait (bounded) for an ack, check it and the outputs that go with it, then drop req
  task automatic waitAck(input int line, input logic [31:0] exp_div, input int exp_owner,
                         input logic exp_err, output int cycles);
    logic seen;
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < 12; i++) begin
      nextCycle();
      cycles++;
      if (ack != 4'd0) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput($sformatf("ack_seen_l%0d", line), {31'd0, seen}, 32'd1);
    checkOutput($sformatf("ack_l%0d", line), {28'd0, ack}, 32'd1 << line);
    checkOutput($sformatf("div_out_l%0d", line), div_out, exp_div);
    checkOutput($sformatf("owner_l%0d", line), {30'd0, owner}, exp_owner);
    checkOutput($sformatf("err_l%0d", line), {31'd0, err}, {31'd0, exp_err});
    req[line] = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    div_in   = '0;
    applyStimulus(4'b0000, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    checkResetValues("reset");
    reset = 1'b0;
    nextCycle();

    // First grant with the generator idle: ack exactly three cycles after req
    $display("[TB] idle grant line 1");
    setDiv(1, 32'd10);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    nextCycle();
    checkOutput("idle_busy_wait", {31'd0, busy}, 32'd1);
    checkOutput("idle_ack_early1", {28'd0, ack}, 32'd0);
    nextCycle();
    checkOutput("idle_ack_early2", {28'd0, ack}, 32'd0);
    checkOutput("idle_div_before", div_out, 32'd2);
    waitAck(1, 32'd10, 1, 1'b0, waited);
    checkOutput("idle_latency", waited, 32'd1);
    checkOutput("idle_gen_enable", {31'd0, gen_enable}, 32'd1);

    // Running change: divider holds until overflow is seen in WAIT
    $display("[TB] running change line 2");
    setDiv(2, 32'd6);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    nextCycle();
    checkOutput("run_busy", {31'd0, busy}, 32'd1);
    checkOutput("run_div_hold1", div_out, 32'd10);
    nextCycle();
    checkOutput("run_div_hold2", div_out, 32'd10);
    checkOutput("run_ack_hold", {28'd0, ack}, 32'd0);
    nextCycle();
    checkOutput("run_div_hold3", div_out, 32'd10);
    gen_overflow = 1'b1;
    nextCycle();
    gen_overflow = 1'b0;
    checkOutput("run_div_load", div_out, 32'd10);
    checkOutput("run_ack_load", {28'd0, ack}, 32'd0);
    waitAck(2, 32'd6, 2, 1'b0, waited);
    checkOutput("run_latency", waited, 32'd1);

    // Rejected request: divider below 2
    $display("[TB] reject line 3");
    setDiv(3, 32'd1);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    nextCycle();
    checkOutput("rej_busy", {31'd0, busy}, 32'd1);
    checkOutput("rej_err_early", {31'd0, err}, 32'd0);
    waitAck(3, 32'd6, 2, 1'b1, waited);
    checkOutput("rej_gen_enable", {31'd0, gen_enable}, 32'd1);
    nextCycle();
    checkOutput("rej_err_clear", {31'd0, err}, 32'd0);
    checkOutput("rej_ack_clear", {28'd0, ack}, 32'd0);

    // Round-robin from pointer 0, overflow held high so each WAIT is one cycle
    $display("[TB] round robin from 0");
    setDiv(0, 32'd4);
    setDiv(1, 32'd8);
    setDiv(2, 32'd12);
    setDiv(3, 32'd16);
    applyStimulus(4'b1111, 1'b0, 1'b1);
    waitAck(0, 32'd4, 0, 1'b0, waited);
    waitAck(1, 32'd8, 1, 1'b0, waited);
    waitAck(2, 32'd12, 2, 1'b0, waited);
    waitAck(3, 32'd16, 3, 1'b0, waited);

    // Move pointer to 2 with a single grant to line 1, then all four again
    $display("[TB] round robin from 2");
    setDiv(1, 32'd20);
    req = 4'b0010;
    waitAck(1, 32'd20, 1, 1'b0, waited);
    setDiv(1, 32'd8);
    req = 4'b1111;
    waitAck(2, 32'd12, 2, 1'b0, waited);
    waitAck(3, 32'd16, 3, 1'b0, waited);
    waitAck(0, 32'd4, 0, 1'b0, waited);
    waitAck(1, 32'd8, 1, 1'b0, waited);

    // Stop and request together: halt wins, request served from IDLE afterwards
    $display("[TB] stop beats request");
    setDiv(0, 32'd30);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    nextCycle();
    stop = 1'b0;
    checkOutput("halt_busy", {31'd0, busy}, 32'd1);
    checkOutput("halt_ack", {28'd0, ack}, 32'd0);
    checkOutput("halt_enable_held", {31'd0, gen_enable}, 32'd1);
    nextCycle();
    checkOutput("halt_enable_held2", {31'd0, gen_enable}, 32'd1);
    gen_overflow = 1'b1;
    nextCycle();
    gen_overflow = 1'b0;
    checkOutput("halt_enable_off", {31'd0, gen_enable}, 32'd0);
    checkOutput("halt_div_kept", div_out, 32'd8);
    checkOutput("halt_idle", {31'd0, busy}, 32'd0);
    waitAck(0, 32'd30, 0, 1'b0, waited);
    checkOutput("halt_regrant_latency", waited, 32'd3);
    checkOutput("halt_regrant_enable", {31'd0, gen_enable}, 32'd1);

    // Reset during WAIT aborts the grant; held req is granted afterwards
    $display("[TB] reset in WAIT");
    setDiv(3, 32'd40);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    nextCycle();
    checkOutput("rst_wait_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    nextCycle();
    checkResetValues("rst_wait");
    reset = 1'b0;
    waitAck(3, 32'd40, 3, 1'b0, waited);
    checkOutput("rst_regrant_latency", waited, 32'd3);
    checkOutput("rst_regrant_enable", {31'd0, gen_enable}, 32'd1);

    nextCycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
